// File: rtl/unified_buffer_write_control_unit_pkg.sv
// Shared types and requant helper for the unified-buffer write path.
// Build option: UB_WR_RELU_EN clamps negative lanes to zero before the shift.
package tpu_package;

    localparam int TILE_DIM  = 32;
    localparam int UB_ADDR_W = 12;
    localparam int ACC_W     = 32;
    localparam int OUT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } ub_wr_state_e;

    typedef struct packed {
        logic [UB_ADDR_W-1:0]      addr;
        logic [TILE_DIM*OUT_W-1:0] data;
        logic [TILE_DIM-1:0]       mask;
    } ub_wr_entry_t;

    function automatic logic [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input logic        [4:0]       sh
    );
        logic signed [ACC_W-1:0] v;
        v = acc;
`ifdef UB_WR_RELU_EN
        if (v < 0) v = '0;
`endif
        v = v >>> sh;
        if (v > 32'sd127) begin
            return 8'h7f;
        end else if (v < -32'sd128) begin
            return 8'h80;
        end
        return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/unified_buffer_write_control_unit_skid.sv
// Two-entry buffer between row acceptance and the unified-buffer write port.
// Entry 0 is always the head; entry 1 only holds data when full.
module ub_write_skid_buffer
    import tpu_package::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  ub_wr_entry_t in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ub_wr_entry_t out_data_o,
    output logic [1:0]   count_o
);

    logic [1:0]   cnt_q;
    ub_wr_entry_t e0_q;
    ub_wr_entry_t e1_q;
    logic         push;
    logic         pop;

    assign out_valid_o = (cnt_q != 2'd0);
    assign in_ready_o  = (cnt_q != 2'd2) | out_ready_i;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = e0_q;
    assign count_o     = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= in_data_i;
                    else               e1_q <= in_data_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= in_data_i;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/unified_buffer_write_control_unit.sv
// Drains accumulator rows into the unified buffer in tile order with requant.
// Build option: UB_WR_RELU_EN (see tpu_package::requant).
module unified_buffer_write_control_unit
    import tpu_package::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [6:0]                U_dim1_i,
    input  logic [6:0]                ITER_dim1_i,
    input  logic [4:0]                shift_i,
    input  logic [UB_ADDR_W-1:0]      unified_buffer_start_addr_wr_i,
    input  logic                      acc_valid_i,
    input  logic [TILE_DIM*ACC_W-1:0] acc_data_i,
    output logic                      acc_ready_o,
    output logic                      unified_buffer_write_en_o,
    output logic [UB_ADDR_W-1:0]      unified_buffer_addr_wr_o,
    output logic [TILE_DIM*OUT_W-1:0] unified_buffer_data_o,
    output logic [TILE_DIM-1:0]       unified_buffer_mask_o,
    input  logic                      unified_buffer_wr_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    ub_wr_state_e         state_q;
    logic [6:0]           u_q;
    logic [6:0]           iter_q;
    logic [4:0]           shift_q;
    logic [UB_ADDR_W-1:0] base_q;
    logic [6:0]           row_q;
    logic [1:0]           tile_x_q;
    logic                 last_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    ub_wr_entry_t         entry_c;
    ub_wr_entry_t         head;
    logic                 sk_in_rdy;
    logic                 sk_out_vld;
    logic [1:0]           sk_cnt;
    logic [1:0]           cnt_nxt;
    logic                 push;
    logic                 pop;
    logic                 last_tile;
    logic                 is_last_row;
    logic                 last_nxt;
    logic [UB_ADDR_W-1:0] span;

    assign push = acc_valid_i & ready_q & sk_in_rdy & (state_q == ST_WRITE);
    assign pop  = sk_out_vld & unified_buffer_wr_ready_i;
    assign cnt_nxt = sk_cnt + {1'b0, push} - {1'b0, pop};

    assign last_tile   = (tile_x_q == iter_q[6:5]);
    assign is_last_row = (row_q == u_q) & last_tile;
    assign last_nxt    = last_q | (push & is_last_row);

    assign span = {5'b0, u_q} + 12'd1;
    assign entry_c.addr = base_q + span * {10'b0, tile_x_q} + {5'b0, row_q};

    // Masked lanes on the ragged final tile are written as zero.
    always_comb begin
        entry_c.mask = '0;
        entry_c.data = '0;
        for (int i = 0; i < TILE_DIM; i++) begin
            entry_c.mask[i] = !last_tile || (5'(i) <= iter_q[4:0]);
            if (entry_c.mask[i]) begin
                entry_c.data[i*OUT_W +: OUT_W] =
                    requant(acc_data_i[i*ACC_W +: ACC_W], shift_q);
            end
        end
    end

    ub_write_skid_buffer u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (push),
        .in_ready_o  (sk_in_rdy),
        .in_data_i   (entry_c),
        .out_valid_o (sk_out_vld),
        .out_ready_i (unified_buffer_wr_ready_i),
        .out_data_o  (head),
        .count_o     (sk_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            u_q      <= '0;
            iter_q   <= '0;
            shift_q  <= '0;
            base_q   <= '0;
            row_q    <= '0;
            tile_x_q <= '0;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q  <= ST_WRITE;
                        u_q      <= U_dim1_i;
                        iter_q   <= ITER_dim1_i;
                        shift_q  <= shift_i;
                        base_q   <= unified_buffer_start_addr_wr_i;
                        row_q    <= '0;
                        tile_x_q <= '0;
                        last_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (push) begin
                        if (row_q == u_q) begin
                            row_q <= '0;
                            if (last_tile) last_q <= 1'b1;
                            else           tile_x_q <= tile_x_q + 2'd1;
                        end else begin
                            row_q <= row_q + 7'd1;
                        end
                    end
                    if (last_q && cnt_nxt == 2'd0) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ready_q <= !last_nxt && (cnt_nxt != 2'd2);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_ready_o               = ready_q;
    assign busy_o                    = busy_q;
    assign done_o                    = done_q;
    assign unified_buffer_write_en_o = pop;
    assign unified_buffer_addr_wr_o  = head.addr;
    assign unified_buffer_data_o     = head.data;
    assign unified_buffer_mask_o     = head.mask;

endmodule

// File: doc/unified_buffer_write_control_unit.md
# unified_buffer_write_control_unit

Writes result rows coming out of the accumulators back into the unified buffer, so the next layer can read them as inputs. Accepts one 32-lane accumulator row per handshake, requantises it to 8-bit lanes, and writes it to a computed unified-buffer address in tile order (x tile outer, y tile inner), with a lane mask on the last x tile. Sits between the accumulator drain port and the unified buffer write port.

## Interface
- LANES, 32, lanes per row (tile width)
- ACC_W, 32, accumulator lane width (signed)
- OUT_W, 8, unified-buffer lane width (signed)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse; latches the dims, base address and shift
- U_dim1_i  in  7  output rows minus 1
- ITER_dim1_i  in  7  output columns minus 1
- shift_i  in  5  arithmetic right shift applied before saturation
- unified_buffer_start_addr_wr_i  in  12  base write address
- acc_valid_i  in  1  accumulator row valid
- acc_data_i  in  LANES*ACC_W  accumulator row, lane 0 in the LSBs
- acc_ready_o  out  1  row accepted when valid and ready are both high
- unified_buffer_write_en_o  out  1  write strobe
- unified_buffer_addr_wr_o  out  12  write address
- unified_buffer_data_o  out  LANES*OUT_W  requantised row
- unified_buffer_mask_o  out  LANES  per-lane write enable
- unified_buffer_wr_ready_i  in  1  buffer port free this cycle (shared with the read side)
- busy_o  out  1  high from start_i until done_o
- done_o  out  1  one-cycle pulse after the last row is written

## Operation
- States:
  - IDLE: start_i moves the block to WRITE and latches all inputs. acc_ready_o is 0.
  - WRITE: accepts rows and issues writes.
  - DONE: pulses done_o for one cycle, then returns to IDLE.
- Counters:
  - row_q runs 0..U_dim1.
  - tile_x_q runs 0..(ITER_dim1>>5).
  - When row_q reaches U_dim1, row_q resets to 0 and tile_x_q increments.
  - The last accepted row is row_q==U_dim1 with tile_x_q==ITER_dim1>>5.
- Address: base + tile_x_q*(U_dim1+1) + row_q, computed in 12-bit arithmetic, wrapping mod 4096 with no error.
- Mask:
  - All ones, except on the last x tile, where lane i is enabled iff i <= ITER_dim1[4:0].
  - Masked lanes still drive data, forced to 0.
- Requant, per lane: compute acc >>> shift_i, then saturate to [-128, 127].
- Buffering: accepted rows pass through a 2-entry skid buffer. acc_ready_o is driven registered from buffer occupancy: 1 iff fewer than 2 entries are held and state is WRITE.
- Write side: the head entry is written when unified_buffer_wr_ready_i is high. Otherwise the head holds and all write outputs hold their values.
- The state goes to DONE only after the last row has been accepted and the skid buffer is empty.
- start_i outside IDLE is ignored.

## Timing
- Reset values of all outputs: 0. Counters are 0, the buffer is empty, and the state is IDLE.
- Latency: a row accepted in cycle N, with the buffer empty and wr_ready high, produces write_en in cycle N+1 with registered address, data and mask.
- Sustained throughput: 1 row/cycle while wr_ready stays high.
- wr_ready low for k cycles stalls writes for exactly k cycles. At most 2 rows are then in flight, and acc_ready_o drops the cycle after the second entry fills.
- Simultaneous push and pop on a full buffer is allowed; occupancy is unchanged.
- done_o asserts the cycle after the final write. busy_o falls in the same cycle.
- Asynchronous reset mid-run: the buffer is flushed, pending writes are discarded, and no done_o is produced.

## Configuration
- UB_WR_RELU_EN:
  - Defined: negative accumulator lanes are clamped to 0 before the shift, so the output range is [0, 127].
  - Undefined: signed saturation only.

## Structure
- tpu_package holds:
  - the state enum type
  - TILE_DIM=32 and the UB_ADDR_W=12 constant
  - the requant function (shift, saturate, optional ReLU under the macro)
- One sub-module, ub_write_skid_buffer: a 2-entry buffer holding {addr, data, mask} with valid/ready on both sides.

## Test plan
- Single row: U_dim1=0, ITER_dim1=31, base=0x100, lanes=i*256, shift=8. Required: one write at 0x100, data lane i = min(i, 127), mask all ones, done_o one cycle later.
- Tile order: U_dim1=39, ITER_dim1=63, base=0x010, continuous valid. Required: 80 writes with addresses 0x010..0x05F, and ready held high throughout.
- Partial tile: ITER_dim1=36. Required: rows in x tile 1 have mask 0x0000001F; x tile 0 rows have mask 0xFFFFFFFF.
- Backpressure: wr_ready low for 5 cycles mid-stream. Required: acc_ready_o low within 2 cycles, no row lost or duplicated, addresses contiguous.
- Saturation and ReLU: lanes of -1000 and +1000, shift=0. Required: -128/127 without UB_WR_RELU_EN, 0/127 with it.
- Reset mid-run: assert rst_ni low after 10 rows. Required: all outputs 0 immediately. A new start_i then begins at row 0 of the new base.
